iic_slave_regif: RTL and testbench
==================================

Name: iic_slave_regif

Overview:
- I2C target (responder) used to model and bench the MS7200/MS7210 register port, and to expose an FPGA-side register bank to an external I2C master.
- Protocol: 7-bit device address, 2-byte register address (MSB first), 1-byte data, auto-increment.
- Open-drain SDA; no clock stretching.
- Sits behind a top-level tristate: iic_sda = sda_out_en ? 1'b0 : 1'bz.

Parameters:
- DEV_ADDR, 7'h2B, 7-bit I2C device address this block answers to.
- FILT_LEN, 3, consecutive equal synchronized samples required before an SCL/SDA level change is accepted (glitch filter).

Ports:
- clk  input  1  system clock; must be ≥ 16x the SCL frequency (10 MHz against 400 kHz is valid).
- rst_n  input  1  asynchronous active-low reset.
- scl_in  input  1  raw SCL pin.
- sda_in  input  1  raw SDA pin.
- sda_out_en  output  1  1 = pull SDA low; 0 = release.
- reg_addr  output  16  current register address.
- reg_wdata  output  8  write data, valid while reg_wr_en = 1.
- reg_wr_en  output  1  one-cycle write strobe.
- reg_rd_en  output  1  one-cycle read request.
- reg_rdata  input  8  read data; sampled exactly 1 clk after reg_rd_en.
- busy  output  1  1 from START until STOP.
- nack_seen  output  1  one-cycle pulse when the master NACKs a read byte.

Behaviour:
- Reset values: sda_out_en=0, reg_addr=0, reg_wdata=0, reg_wr_en=0, reg_rd_en=0, busy=0, nack_seen=0, state=IDLE.
- Input conditioning:
  - 2-FF synchronizer, then FILT_LEN filter, on each line.
  - scl_rise / scl_fall are single-cycle pulses on filtered edges.
- Bus conditions:
  - START = filtered SDA falls while SCL=1; STOP = filtered SDA rises while SCL=1.
  - Both are detected in any state and take priority over bit processing.
  - START (including repeated START) → DEV state, bit counter cleared, sda_out_en=0.
  - STOP → IDLE, busy=0, sda_out_en=0.
- Bit timing:
  - Incoming bits sampled on scl_rise, MSB first.
  - sda_out_en changes only on scl_fall; the first read-data bit is driven on the scl_fall that ends the address-ACK clock.
- States:
  - IDLE: waits for START.
  - DEV: shift 8 bits.
    - Bits[7:1] ≠ DEV_ADDR → IGNORE (no ACK; stay until START/STOP).
    - Match with R/W=0 → ACK → ADDR_H.
    - Match with R/W=1 → ACK → issue reg_rd_en with current reg_addr → RDATA.
  - ADDR_H: shift 8 bits → reg_addr[15:8] → ACK → ADDR_L.
  - ADDR_L: shift 8 bits → reg_addr[7:0] → ACK → WDATA.
  - WDATA: shift 8 bits → ACK.
    - Sequence on 8th scl_rise: +1 clk reg_wdata valid and reg_wr_en=1 for 1 clk at the current reg_addr; +2 clk reg_addr increments.
  - RDATA:
    - Drive shift-register bit: sda_out_en = ~bit (a 1 bit releases SDA).
    - After the 8th bit's scl_fall, release SDA → MACK.
  - MACK: sample SDA on scl_rise.
    - 0 (ACK): reg_addr+1, reg_rd_en, load → RDATA.
    - 1 (NACK): nack_seen pulse, reg_addr+1, → IGNORE.
  - ACK phase (every ACK state): sda_out_en=1 from the scl_fall after bit 8 until the next scl_fall.
- Arithmetic: reg_addr wraps 16'hFFFF → 16'h0000.
- reg_addr is retained across transactions, so read-after-write-pointer (write address, repeated START, read) works.
- STOP or START mid-byte: the partial byte is discarded, with no reg_wr_en. A write whose 8th bit completed before the STOP is kept.
- Reset mid-transaction: immediate return to reset values; SDA released within the same cycle.

Test Plan:
- Write of 2 bytes to DEV_ADDR=7'h2B: START, 0x56, 0x12, 0x34, 0xA5, 0x5A, STOP → ACK on all 5 bytes; reg_wr_en pulses (0x1234, 0xA5) then (0x1235, 0x5A); busy low after STOP.
- Random read: START, 0x56, 0x00, 0x10, repeated START, 0x57, then master ACK, ACK, NACK, with reg_rdata returning addr[7:0] → SDA bytes 0x10, 0x11, 0x12; three reg_rd_en pulses at 0x0010, 0x0011, 0x0012; nack_seen pulse; reg_addr=0x0013.
- Wrong address 0x58 → SDA never driven low; no reg strobes; next START with 0x56 is ACKed normally.
- Wrap: write pointer 0xFFFF, data 0x11, 0x22 → writes at 0xFFFF, then 0x0000.
- Abort: STOP after 4 bits of a data byte → no reg_wr_en, state IDLE, sda_out_en=0. Also assert rst_n=0 during the ACK phase → sda_out_en=0 immediately.
- Glitch: a 1-clk low pulse on SCL while high → no bit shifted, no START/STOP detected (FILT_LEN=3).

Source files
------------

// File: rtl/iic_slave_regif.sv
// I2C target exposing a 16-bit-addressed, 8-bit-wide register port.
// 7-bit device address, 2-byte register pointer (MSB first), auto-increment, no clock stretching.
module iic_slave_regif #(
   parameter logic [6:0]  DEV_ADDR = 7'h2B,
   parameter int unsigned FILT_LEN = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_out_en,
   output logic [15:0] reg_addr,
   output logic [7:0]  reg_wdata,
   output logic        reg_wr_en,
   output logic        reg_rd_en,
   input  logic [7:0]  reg_rdata,
   output logic        busy,
   output logic        nack_seen
);

   typedef enum logic [3:0] {
      S_IDLE, S_DEV, S_ADDR_H, S_ADDR_L, S_WDATA, S_ACK, S_RDATA, S_MACK, S_IGNORE
   } state_t;

   state_t              r_state, r_next;
   logic [1:0]          r_scl_sync, r_sda_sync;
   logic [FILT_LEN-1:0] r_scl_hist, r_sda_hist;
   logic                r_scl_f, r_sda_f, r_scl_q, r_sda_q;
   logic [7:0]          r_shift;
   logic [3:0]          r_bitcnt;
   logic                r_ack_on, r_rd_req, r_rd_pend;

   logic       w_scl_rise, w_scl_fall, w_start, w_stop;
   logic [7:0] w_byte;

   // Lines idle high, so the conditioning chain resets to 1 to avoid a false START on reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_hist <= '1;
         r_sda_hist <= '1;
         r_scl_f    <= 1'b1;
         r_sda_f    <= 1'b1;
         r_scl_q    <= 1'b1;
         r_sda_q    <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[0], scl_in};
         r_sda_sync <= {r_sda_sync[0], sda_in};
         r_scl_hist <= {r_scl_hist[FILT_LEN-2:0], r_scl_sync[1]};
         r_sda_hist <= {r_sda_hist[FILT_LEN-2:0], r_sda_sync[1]};
         if (&r_scl_hist)       r_scl_f <= 1'b1;
         else if (~|r_scl_hist) r_scl_f <= 1'b0;
         if (&r_sda_hist)       r_sda_f <= 1'b1;
         else if (~|r_sda_hist) r_sda_f <= 1'b0;
         r_scl_q <= r_scl_f;
         r_sda_q <= r_sda_f;
      end
   end

   assign w_scl_rise = r_scl_f & ~r_scl_q;
   assign w_scl_fall = ~r_scl_f & r_scl_q;
   assign w_start    = r_scl_f & r_scl_q & r_sda_q & ~r_sda_f;
   assign w_stop     = r_scl_f & r_scl_q & ~r_sda_q & r_sda_f;
   assign w_byte     = {r_shift[6:0], r_sda_f};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_next     <= S_IDLE;
         r_shift    <= '0;
         r_bitcnt   <= '0;
         r_ack_on   <= 1'b0;
         r_rd_req   <= 1'b0;
         r_rd_pend  <= 1'b0;
         sda_out_en <= 1'b0;
         reg_addr   <= '0;
         reg_wdata  <= '0;
         reg_wr_en  <= 1'b0;
         reg_rd_en  <= 1'b0;
         busy       <= 1'b0;
         nack_seen  <= 1'b0;
      end else begin
         reg_wr_en <= 1'b0;
         nack_seen <= 1'b0;
         reg_rd_en <= r_rd_req;
         r_rd_req  <= 1'b0;
         r_rd_pend <= reg_rd_en;
         // Read data is captured one clock after the request strobe.
         if (r_rd_pend) r_shift <= reg_rdata;
         if (reg_wr_en) reg_addr <= reg_addr + 16'd1;

         if (w_start) begin
            r_state    <= S_DEV;
            r_bitcnt   <= '0;
            sda_out_en <= 1'b0;
            busy       <= 1'b1;
         end else if (w_stop) begin
            r_state    <= S_IDLE;
            sda_out_en <= 1'b0;
            busy       <= 1'b0;
         end else begin
            case (r_state)
               S_DEV, S_ADDR_H, S_ADDR_L, S_WDATA: begin
                  if (w_scl_rise) begin
                     r_shift  <= w_byte;
                     r_bitcnt <= r_bitcnt + 4'd1;
                     if (r_bitcnt == 4'd7) begin
                        r_bitcnt <= '0;
                        r_ack_on <= 1'b0;
                        r_state  <= S_ACK;
                        if (r_state == S_DEV) begin
                           if (w_byte[7:1] == DEV_ADDR)
                              r_next <= w_byte[0] ? S_RDATA : S_ADDR_H;
                           else
                              r_state <= S_IGNORE;
                        end else if (r_state == S_ADDR_H) begin
                           reg_addr[15:8] <= w_byte;
                           r_next         <= S_ADDR_L;
                        end else if (r_state == S_ADDR_L) begin
                           reg_addr[7:0] <= w_byte;
                           r_next        <= S_WDATA;
                        end else begin
                           reg_wdata <= w_byte;
                           reg_wr_en <= 1'b1;
                           r_next    <= S_WDATA;
                        end
                     end
                  end
               end
               S_ACK: begin
                  if (w_scl_fall) begin
                     if (!r_ack_on) begin
                        sda_out_en <= 1'b1;
                        r_ack_on   <= 1'b1;
                        if (r_next == S_RDATA) r_rd_req <= 1'b1;
                     end else begin
                        r_ack_on <= 1'b0;
                        r_state  <= r_next;
                        r_bitcnt <= '0;
                        if (r_next == S_RDATA) begin
                           // The fall that ends the address ACK also drives the first data bit.
                           sda_out_en <= ~r_shift[7];
                           r_shift    <= {r_shift[6:0], 1'b0};
                           r_bitcnt   <= 4'd1;
                        end else begin
                           sda_out_en <= 1'b0;
                        end
                     end
                  end
               end
               S_RDATA: begin
                  if (w_scl_fall) begin
                     if (r_bitcnt == 4'd8) begin
                        sda_out_en <= 1'b0;
                        r_state    <= S_MACK;
                     end else begin
                        sda_out_en <= ~r_shift[7];
                        r_shift    <= {r_shift[6:0], 1'b0};
                        r_bitcnt   <= r_bitcnt + 4'd1;
                     end
                  end
               end
               S_MACK: begin
                  if (w_scl_rise) begin
                     reg_addr <= reg_addr + 16'd1;
                     r_bitcnt <= '0;
                     if (!r_sda_f) begin
                        r_rd_req <= 1'b1;
                        r_state  <= S_RDATA;
                     end else begin
                        nack_seen <= 1'b1;
                        r_state   <= S_IGNORE;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_iic_slave_regif.sv
// Directed bench for iic_slave_regif: bit-banged I2C master on an open-drain bus with strobe monitors.
`timescale 1ns/1ps
module tb_iic_slave_regif;

   localparam int Q = 1000;  // quarter SCL period: 10 system clocks

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        m_scl = 1'b1;
   logic        m_sda = 1'b1;
   logic        sda_out_en;
   logic [15:0] reg_addr;
   logic [7:0]  reg_wdata;
   logic        reg_wr_en, reg_rd_en, busy, nack_seen;
   logic [7:0]  reg_rdata;
   logic        sda_bus;

   int n_chk = 0;
   int n_pass = 0;

   logic [15:0] wr_a[$];
   logic [7:0]  wr_d[$];
   logic [15:0] rd_a[$];
   int          nack_n = 0;
   int          low_n = 0;

   always #50 clk = ~clk;

   assign sda_bus   = m_sda & ~sda_out_en;
   assign reg_rdata = reg_addr[7:0];

   iic_slave_regif #(.DEV_ADDR(7'h2B), .FILT_LEN(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .scl_in     (m_scl),
      .sda_in     (sda_bus),
      .sda_out_en (sda_out_en),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_wr_en  (reg_wr_en),
      .reg_rd_en  (reg_rd_en),
      .reg_rdata  (reg_rdata),
      .busy       (busy),
      .nack_seen  (nack_seen)
   );

   always @(negedge clk) begin
      if (reg_wr_en) begin
         wr_a.push_back(reg_addr);
         wr_d.push_back(reg_wdata);
      end
      if (reg_rd_en) rd_a.push_back(reg_addr);
      if (nack_seen) nack_n++;
      if (sda_out_en) low_n++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic i2c_start;
      m_sda = 1'b1; #Q;
      m_scl = 1'b1; #Q;
      m_sda = 1'b0; #Q;
      m_scl = 1'b0; #Q;
   endtask

   task automatic i2c_stop;
      m_sda = 1'b0; #Q;
      m_scl = 1'b1; #Q;
      m_sda = 1'b1; #(2*Q);
   endtask

   task automatic write_bit(input logic b, input logic glitch);
      m_sda = b; #Q;
      m_scl = 1'b1;
      if (glitch) begin
         #Q; m_scl = 1'b0; #100; m_scl = 1'b1; #(Q-100);
      end else begin
         #(2*Q);
      end
      m_scl = 1'b0; #Q;
   endtask

   task automatic read_bit(output logic b);
      m_sda = 1'b1; #Q;
      m_scl = 1'b1; #Q;
      b = sda_bus; #Q;
      m_scl = 1'b0; #Q;
   endtask

   task automatic send_byte(input logic [7:0] d, input int gbit, output logic ack);
      logic x;
      for (int i = 7; i >= 0; i--) write_bit(d[i], i == gbit);
      read_bit(x);
      ack = ~x;
   endtask

   task automatic recv_byte(output logic [7:0] d, input logic nack);
      logic x;
      for (int i = 7; i >= 0; i--) begin
         read_bit(x);
         d[i] = x;
      end
      write_bit(nack, 1'b0);
   endtask

   initial begin
      logic       ack;
      logic [7:0] rb;
      int         wb, rbase, nb, lb;

      @(negedge clk); #1000;
      check("rst_sda_en", sda_out_en, 0);
      check("rst_addr",   reg_addr, 0);
      check("rst_wdata",  reg_wdata, 0);
      check("rst_strobes", {reg_wr_en, reg_rd_en, nack_seen}, 0);
      check("rst_busy",   busy, 0);
      rst_n = 1'b1;
      #(4*Q);

      // Two-byte write at 0x1234
      wb = wr_a.size();
      i2c_start;
      check("wr_busy", busy, 1);
      send_byte(8'h56, -1, ack); check("wr_ack_dev", ack, 1);
      send_byte(8'h12, -1, ack); check("wr_ack_ah", ack, 1);
      send_byte(8'h34, -1, ack); check("wr_ack_al", ack, 1);
      send_byte(8'hA5, -1, ack); check("wr_ack_d0", ack, 1);
      send_byte(8'h5A, -1, ack); check("wr_ack_d1", ack, 1);
      i2c_stop;
      check("wr_cnt", wr_a.size() - wb, 2);
      check("wr0", {wr_a[wb], wr_d[wb]}, 24'h1234A5);
      check("wr1", {wr_a[wb+1], wr_d[wb+1]}, 24'h12355A);
      check("wr_addr_end", reg_addr, 16'h1236);
      check("wr_busy_end", busy, 0);

      // Random read: pointer 0x0010, repeated START, three bytes
      rbase = rd_a.size(); nb = nack_n;
      i2c_start;
      send_byte(8'h56, -1, ack);
      send_byte(8'h00, -1, ack);
      send_byte(8'h10, -1, ack);
      i2c_start;
      send_byte(8'h57, -1, ack); check("rd_ack_dev", ack, 1);
      recv_byte(rb, 1'b0); check("rd_b0", rb, 8'h10);
      recv_byte(rb, 1'b0); check("rd_b1", rb, 8'h11);
      recv_byte(rb, 1'b1); check("rd_b2", rb, 8'h12);
      i2c_stop;
      check("rd_cnt", rd_a.size() - rbase, 3);
      check("rd_addrs", {rd_a[rbase], rd_a[rbase+1], rd_a[rbase+2]}, 48'h0010_0011_0012);
      check("rd_nack", nack_n - nb, 1);
      check("rd_addr_end", reg_addr, 16'h0013);

      // Foreign device address is ignored
      wb = wr_a.size(); rbase = rd_a.size(); lb = low_n;
      i2c_start;
      send_byte(8'h58, -1, ack); check("na_ack", ack, 0);
      send_byte(8'h00, -1, ack); check("na_ack2", ack, 0);
      i2c_stop;
      check("na_low", low_n - lb, 0);
      check("na_strobes", (wr_a.size() - wb) + (rd_a.size() - rbase), 0);
      i2c_start;
      send_byte(8'h56, -1, ack); check("na_recover", ack, 1);
      i2c_stop;

      // Pointer wrap 0xFFFF -> 0x0000
      wb = wr_a.size();
      i2c_start;
      send_byte(8'h56, -1, ack);
      send_byte(8'hFF, -1, ack);
      send_byte(8'hFF, -1, ack);
      send_byte(8'h11, -1, ack);
      send_byte(8'h22, -1, ack);
      i2c_stop;
      check("wrap_w0", {wr_a[wb], wr_d[wb]}, 24'hFFFF11);
      check("wrap_w1", {wr_a[wb+1], wr_d[wb+1]}, 24'h000022);
      check("wrap_addr", reg_addr, 16'h0001);

      // SCL glitch inside a data bit and idle-bus glitches
      wb = wr_a.size();
      i2c_start;
      send_byte(8'h56, -1, ack);
      send_byte(8'h00, -1, ack);
      send_byte(8'h40, -1, ack);
      send_byte(8'h3C, 3, ack); check("gl_ack", ack, 1);
      i2c_stop;
      check("gl_wr", {wr_a[wb], wr_d[wb]}, 24'h00403C);
      check("gl_cnt", wr_a.size() - wb, 1);
      m_sda = 1'b0; #100; m_sda = 1'b1; #(2*Q);
      check("gl_sda_nostart", busy, 0);
      m_sda = 1'b0; #(2*Q);
      m_scl = 1'b0; #100; m_scl = 1'b1; #Q;
      m_sda = 1'b1; #(2*Q);
      check("gl_scl_busy", busy, 0);

      // STOP after four data bits discards the byte
      wb = wr_a.size();
      i2c_start;
      send_byte(8'h56, -1, ack);
      send_byte(8'h00, -1, ack);
      send_byte(8'h20, -1, ack);
      for (int i = 0; i < 4; i++) write_bit(1'b1, 1'b0);
      i2c_stop;
      check("ab_nowr", wr_a.size() - wb, 0);
      check("ab_sda", sda_out_en, 0);
      check("ab_busy", busy, 0);

      // Reset during the ACK clock releases SDA at once
      i2c_start;
      for (int i = 7; i >= 0; i--) write_bit(((8'h56 >> i) & 1) != 0, 1'b0);
      check("rs_ack_drv", sda_out_en, 1);
      #30;
      rst_n = 1'b0;
      #1;
      check("rs_sda", sda_out_en, 0);
      check("rs_addr", reg_addr, 0);
      m_sda = 1'b1; m_scl = 1'b1;
      #(2*Q);
      rst_n = 1'b1;
      #(2*Q);
      check("rs_busy", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
